shift_unit_pipe: RTL and testbench
==================================

// Module: shift_unit_pipe
// PURPOSE
//  Parametrised, pipelined shift unit for the integer execute stage; generalises the
//  combinational arithmetic right shifter. Performs SLL/SRL/SRA (optionally ROL/ROR)
//  on XLEN-bit operands, spreading log2(XLEN) mux levels over PIPE register stages.
//  Uses valid/ready handshakes on both sides and carries a tag alongside each result.
// PARAMETERS
//  XLEN  32  operand/result width; power of two, >= 8
//  PIPE  2   register stages, 1..$clog2(XLEN); latency = PIPE cycles
//  TAGW  5   width of the tag carried with each op (e.g. rd index)
//  (local) SHW = $clog2(XLEN)  shift-amount width
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  flush      in   1     synchronous flush of all in-flight ops
//  in_valid   in   1     input op valid
//  in_ready   out  1     unit can accept an op this cycle
//  in_op      in   3     000 SLL, 001 SRL, 010 SRA, 100 ROL, 101 ROR
//  in_data    in   XLEN  operand
//  in_shamt   in   SHW   shift amount (only low SHW bits, no masking beyond)
//  in_tag     in   TAGW  passthrough tag
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer accepts result
//  out_data   out  XLEN  result
//  out_tag    out  TAGW  tag of result
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valid bits 0; out_valid=0, out_data=0,
//    out_tag=0; in_ready=1 once reset deasserts. Reset mid-operation drops ops.
//  - Transfer occurs when valid&&ready on a side. Stage k advances when stage k+1
//    is empty or advancing; last stage advances when out_ready or !out_valid.
//  - in_ready = !stage0_valid || stage0_advances (combinational from out_ready;
//    no bubble under full throughput: 1 op/cycle sustained).
//  - Accepted op appears on out_* exactly PIPE cycles later if never stalled.
//    Stalled stages hold data, op, shamt and tag unchanged.
//  - Shift levels: level i shifts by 2^i if shamt[i]; levels assigned to stages in
//    order, ceil(SHW/PIPE) levels per stage, remainder in the last stage.
//  - SRA fills with operand MSB; SRL/SLL fill 0. shamt=0 -> out_data=in_data.
//  - Unsupported op code: out_data=in_data (passthrough), still handshaked.
//  - out_valid held with stable out_data/out_tag until out_ready.
//  - flush=1: all stage valid bits cleared next edge, out_valid=0; input offered
//    in the same cycle is not accepted (in_ready=0 while flush=1).
//  - flush and rst_n low together: reset wins.
// CONFIGURATION
//  ROTATE_EN defined: ROL (100) and ROR (101) implemented; rotated-out bits wrap
//    to the opposite end; level muxes gain the rotate input.
//  ROTATE_EN undefined: 100/101 are unsupported codes -> passthrough; no extra
//    logic. All other behaviour identical.
// TESTING
//  1 SRA 0x40000000, shamt 2, tag 3 -> out 0x10000000, tag 3, after PIPE cycles.
//  2 SRA 0x80000000 sh 31 -> 0xFFFFFFFF; SRL same -> 0x00000001;
//    SLL 0x00000001 sh 31 -> 0x80000000; any op sh 0 -> operand unchanged.
//  3 Back-to-back 30 SRA ops shamt 0..29, out_ready=1 -> one result per cycle,
//    in order, tags match, no in_ready drop.
//  4 Hold out_ready=0 for 5 cycles with pipe full -> in_ready=0, out_data stable;
//    release -> all results drain in order, none lost or duplicated.
//  5 rst_n pulse low with 2 ops in flight -> out_valid=0, out_data=0 immediately;
//    flush=1 likewise empties pipe next edge and refuses concurrent input.
//  6 ROTATE_EN: ROL 0x80000001 sh 1 -> 0x00000003; ROR 0x00000003 sh 1 ->
//    0x80000001. Without ROTATE_EN: same ops -> operand passthrough.

Source files
------------

// File: rtl/shift_unit_pipe.sv
// Pipelined SLL/SRL/SRA shifter with valid/ready handshakes on both sides.
// Define ROTATE_EN to add ROL/ROR; without it those codes pass the operand through.
module shift_unit_pipe #(
  parameter int XLEN = 32,
  parameter int PIPE = 2,
  parameter int TAGW = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic [XLEN-1:0]         in_data,
  input  logic [$clog2(XLEN)-1:0] in_shamt,
  input  logic [TAGW-1:0]         in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [TAGW-1:0]         out_tag
);

  localparam int SHW = $clog2(XLEN);
  localparam int LPS = (SHW + PIPE - 1) / PIPE;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
`ifdef ROTATE_EN
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
`endif

  // Applies only the mux levels owned by stage stg (level i lives in stage i/LPS).
  function automatic logic [XLEN-1:0] shift_grp(
    input logic [XLEN-1:0] d,
    input logic [2:0]      op,
    input logic [SHW-1:0]  sh,
    input int              stg
  );
    logic [XLEN-1:0] r;
    r = d;
    for (int i = 0; i < SHW; i++) begin
      if ((i / LPS) == stg && sh[i]) begin
        unique case (op)
          OP_SLL: r = r << (1 << i);
          OP_SRL: r = r >> (1 << i);
          OP_SRA: r = $signed(r) >>> (1 << i);
`ifdef ROTATE_EN
          OP_ROL: r = (r << (1 << i)) | (r >> (XLEN - (1 << i)));
          OP_ROR: r = (r >> (1 << i)) | (r << (XLEN - (1 << i)));
`endif
          default: r = r;
        endcase
      end
    end
    return r;
  endfunction

  logic [PIPE-1:0] vld_q;
  logic [XLEN-1:0] data_q [PIPE];
  logic [2:0]      op_q   [PIPE];
  logic [SHW-1:0]  sh_q   [PIPE];
  logic [TAGW-1:0] tag_q  [PIPE];

  logic [PIPE-1:0] en;
  logic [PIPE-1:0] vld_d;
  logic [XLEN-1:0] data_d [PIPE];
  logic [2:0]      op_d   [PIPE];
  logic [SHW-1:0]  sh_d   [PIPE];
  logic [TAGW-1:0] tag_d  [PIPE];

  // A stage may load when it is empty or its successor is loading.
  always_comb begin
    logic run;
    en  = '0;
    run = !vld_q[PIPE-1] || out_ready;
    en[PIPE-1] = run;
    for (int k = PIPE - 2; k >= 0; k--) begin
      run   = !vld_q[k] || run;
      en[k] = run;
    end
  end

  assign in_ready = en[0] && !flush;

  always_comb begin
    vld_d     = '0;
    vld_d[0]  = in_valid && in_ready;
    data_d[0] = shift_grp(in_data, in_op, in_shamt, 0);
    op_d[0]   = in_op;
    sh_d[0]   = in_shamt;
    tag_d[0]  = in_tag;
    for (int k = 1; k < PIPE; k++) begin
      vld_d[k]  = vld_q[k-1];
      data_d[k] = shift_grp(data_q[k-1], op_q[k-1], sh_q[k-1], k);
      op_d[k]   = op_q[k-1];
      sh_d[k]   = sh_q[k-1];
      tag_d[k]  = tag_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < PIPE; k++) begin
        data_q[k] <= '0;
        op_q[k]   <= '0;
        sh_q[k]   <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE; k++) begin
        if (flush) begin
          vld_q[k] <= 1'b0;
        end else if (en[k]) begin
          vld_q[k] <= vld_d[k];
        end
        if (!flush && en[k] && vld_d[k]) begin
          data_q[k] <= data_d[k];
          op_q[k]   <= op_d[k];
          sh_q[k]   <= sh_d[k];
          tag_q[k]  <= tag_d[k];
        end
      end
    end
  end

  assign out_valid = vld_q[PIPE-1];
  assign out_data  = data_q[PIPE-1];
  assign out_tag   = tag_q[PIPE-1];

  logic unused_last;
  assign unused_last = ^{op_q[PIPE-1], sh_q[PIPE-1]};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe: vector table plus stall/reset/flush cases.
// Rotate expectations follow ROTATE_EN.
module tb_shift_unit_pipe;

  localparam int XLEN = 32;
  localparam int PIPE = 2;
  localparam int TAGW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_op = '0;
  logic [XLEN-1:0] in_data = '0;
  logic [4:0]      in_shamt = '0;
  logic [TAGW-1:0] in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_data;
  logic [TAGW-1:0] out_tag;

  shift_unit_pipe #(.XLEN(XLEN), .PIPE(PIPE), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data),
    .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d;
    logic [4:0]  sh;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t tv [NV];

  int tests = 0;
  int fails = 0;
  int lat, drops, got, cyc, first, last, seen, nacc;
  logic [31:0] ex [30];
  logic [31:0] sq [$];
  logic [31:0] held;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] d,
                       input logic [4:0] sh, input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
    in_tag   = tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench timed out");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{3'b010, 32'h4000_0000, 5'd2,  5'd3,  32'h1000_0000};
    tv[1]  = '{3'b010, 32'h8000_0000, 5'd31, 5'd4,  32'hFFFF_FFFF};
    tv[2]  = '{3'b001, 32'h8000_0000, 5'd31, 5'd5,  32'h0000_0001};
    tv[3]  = '{3'b000, 32'h0000_0001, 5'd31, 5'd6,  32'h8000_0000};
    tv[4]  = '{3'b000, 32'h1234_5678, 5'd0,  5'd7,  32'h1234_5678};
    tv[5]  = '{3'b010, 32'hF0F0_F0F0, 5'd0,  5'd8,  32'hF0F0_F0F0};
    tv[6]  = '{3'b001, 32'h1234_5678, 5'd4,  5'd9,  32'h0123_4567};
    tv[7]  = '{3'b000, 32'h1234_5678, 5'd8,  5'd10, 32'h3456_7800};
    tv[8]  = '{3'b010, 32'h8765_4321, 5'd4,  5'd11, 32'hF876_5432};
    tv[9]  = '{3'b010, 32'h7FFF_FFFF, 5'd16, 5'd12, 32'h0000_7FFF};
    tv[10] = '{3'b011, 32'hDEAD_BEEF, 5'd5,  5'd13, 32'hDEAD_BEEF};
    tv[11] = '{3'b111, 32'hCAFE_F00D, 5'd3,  5'd14, 32'hCAFE_F00D};
    tv[12] = '{3'b010, 32'hA5A5_A5A5, 5'd1,  5'd15, 32'hD2D2_D2D2};
    tv[13] = '{3'b001, 32'hFFFF_FFFF, 5'd31, 5'd16, 32'h0000_0001};
`ifdef ROTATE_EN
    tv[14] = '{3'b100, 32'h8000_0001, 5'd1,  5'd17, 32'h0000_0003};
    tv[15] = '{3'b101, 32'h0000_0003, 5'd1,  5'd18, 32'h8000_0001};
    tv[16] = '{3'b100, 32'h1234_5678, 5'd4,  5'd19, 32'h2345_6781};
`else
    tv[14] = '{3'b100, 32'h8000_0001, 5'd1,  5'd17, 32'h8000_0001};
    tv[15] = '{3'b101, 32'h0000_0003, 5'd1,  5'd18, 32'h0000_0003};
    tv[16] = '{3'b100, 32'h1234_5678, 5'd4,  5'd19, 32'h1234_5678};
`endif

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // single ops from the table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i].op, tv[i].d, tv[i].sh, tv[i].tag);
      #1;
      chk("vec_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), lat, PIPE);
      chk($sformatf("vec%0d_data", i), out_data, tv[i].exp);
      chk($sformatf("vec%0d_tag", i), {27'd0, out_tag}, {27'd0, tv[i].tag});
    end
    @(negedge clk);

    // back-to-back SRA, one per cycle
    for (int k = 0; k < 30; k++) begin
      logic signed [31:0] s;
      s = k[0] ? 32'h9ABC_DEF0 : 32'h4321_0FED;
      ex[k] = s >>> k;
    end
    drops = 0; got = 0; cyc = 0; first = -1; last = -1;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          drive(3'b010, k[0] ? 32'h9ABC_DEF0 : 32'h4321_0FED,
                k[4:0], k[4:0]);
          #1;
          if (!in_ready) drops++;
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        while (got < 30 && cyc < 100) begin
          @(negedge clk);
          cyc++;
          if (out_valid) begin
            if (first < 0) first = cyc;
            last = cyc;
            chk("b2b_data", out_data, ex[got]);
            chk("b2b_tag", {27'd0, out_tag}, got);
            got++;
          end
        end
      end
    join
    chk("b2b_in_ready_drops", drops, 0);
    chk("b2b_count", got, 30);
    chk("b2b_span", last - first, 29);

    // stall with full pipe
    @(negedge clk);
    out_ready = 1'b0;
    nacc = 0;
    sq.delete();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 2) begin
        if (c == 2) held = out_data;
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data_hold", out_data, held);
        chk("stall_data", out_data, 32'h1 << 1);
      end
      drive(3'b000, 32'h1, 5'(nacc + 1), 5'(nacc + 10));
      #1;
      if (in_ready) begin
        sq.push_back(32'h1 << (nacc + 1));
        nacc++;
      end
    end
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_accepted", nacc, PIPE);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < nacc && cyc < 20) begin
      if (out_valid) begin
        chk("drain_data", out_data, sq[got]);
        chk("drain_tag", {27'd0, out_tag}, got + 10);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("drain_count", got, nacc);
    seen = 0;
    repeat (3) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("drain_no_dup", seen, 0);

    // async reset with two ops in flight
    drive(3'b001, 32'hFFFF_0000, 5'd4, 5'd21);
    @(negedge clk);
    drive(3'b001, 32'h0F0F_0000, 5'd8, 5'd22);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstmid_pre_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_data", out_data, 32'd0);
    chk("rstmid_tag", {27'd0, out_tag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rstmid_dropped", seen, 0);
    chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);

    // flush with two ops in flight and a third offered
    drive(3'b000, 32'h0000_00FF, 5'd4, 5'd23);
    @(negedge clk);
    drive(3'b000, 32'h0000_0F00, 5'd4, 5'd24);
    @(negedge clk);
    drive(3'b010, 32'h8000_0000, 5'd1, 5'd25);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_emptied", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
